// File: rtl/traf_sig_monitor_if.sv
// Signal-code inputs and lamp/fault outputs of the traffic signal monitor.
interface traf_sig_monitor_if;
  logic [1:0] main_sig;
  logic [1:0] cntry_sig;
  logic       fault_ack;
  logic [2:0] main_lamp;
  logic [2:0] cntry_lamp;
  logic       fault;
  logic [2:0] fault_code;

  // The controller side drives codes and acknowledge, and watches the lamps.
  modport master (
    output main_sig, cntry_sig, fault_ack,
    input  main_lamp, cntry_lamp, fault, fault_code
  );

  // The monitor side consumes codes and drives the lamps.
  modport slave (
    input  main_sig, cntry_sig, fault_ack,
    output main_lamp, cntry_lamp, fault, fault_code
  );
endinterface

// File: rtl/traf_sig_monitor.sv
// Traffic signal monitor: decodes controller codes into one-hot lamp drives,
// checks the signal sequence for safety violations, and forces flashing red
// on both roads after the first violation until it is acknowledged.
module traf_sig_monitor #(
  parameter int MIN_Y_CYC  = 3,
  parameter int MIN_R_CYC  = 2,
  parameter int FLASH_HALF = 4
) (
  input  logic              clock,
  input  logic              clear,
  traf_sig_monitor_if.slave bus
);

  localparam int YW = $clog2(MIN_Y_CYC + 1);
  localparam int RW = $clog2(MIN_R_CYC + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(MIN_Y_CYC);
  localparam logic [RW-1:0] R_MAX  = RW'(MIN_R_CYC);
  localparam logic [FW-1:0] F_LAST = FW'(FLASH_HALF - 1);

  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YEL = 2'd1;
  localparam logic [1:0] GRN = 2'd2;
  localparam logic [1:0] ILL = 2'd3;

  typedef enum logic {MONITOR = 1'b0, FAULT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sm_q, sc_q, pm_q, pc_q;
  logic [YW-1:0]   yelMain_q, yelMain_d, yelCntry_q, yelCntry_d;
  logic [RW-1:0]   allRed_q, allRed_d;
  logic            flash_q, flash_d;
  logic [FW-1:0]   flashCnt_q, flashCnt_d;
  logic [2:0]      mainLamp_q, mainLamp_d, cntryLamp_q, cntryLamp_d;
  logic [2:0]      faultCode_q, faultCode_d;
  logic [2:0]      vioCode;
  logic            exitFault;

  function automatic logic [2:0] lampDecode(input logic [1:0] code);
    case (code)
      YEL:     lampDecode = 3'b010;
      GRN:     lampDecode = 3'b001;
      default: lampDecode = 3'b100;
    endcase
  endfunction

  function automatic logic badTrans(input logic [1:0] prev, input logic [1:0] cur);
    badTrans = (prev == GRN && cur == RED) ||
               (prev == RED && cur == YEL) ||
               (prev == YEL && cur == GRN);
  endfunction

  // Leaving FAULT needs an acknowledge while both roads already show red.
  assign exitFault = (state_q == FAULT) && bus.fault_ack && (sm_q == RED) && (sc_q == RED);

  // Evaluate all checks; later assignments win so the lowest code has priority.
  always_comb begin
    vioCode = 3'd0;
    if (((pm_q == RED && sm_q == GRN) || (pc_q == RED && sc_q == GRN)) && (allRed_q < R_MAX))
      vioCode = 3'd5;
    if ((pm_q == YEL && sm_q == RED && yelMain_q < Y_MAX) ||
        (pc_q == YEL && sc_q == RED && yelCntry_q < Y_MAX))
      vioCode = 3'd4;
    if (badTrans(pm_q, sm_q) || badTrans(pc_q, sc_q))
      vioCode = 3'd3;
    if (sm_q != RED && sc_q != RED)
      vioCode = 3'd2;
    if (sm_q == ILL || sc_q == ILL)
      vioCode = 3'd1;
  end

  // Saturating yellow and all-red counters, zeroed when a fault is cleared.
  always_comb begin
    yelMain_d  = '0;
    yelCntry_d = '0;
    allRed_d   = '0;
    if (!exitFault) begin
      if (sm_q == YEL)
        yelMain_d = (yelMain_q == Y_MAX) ? yelMain_q : yelMain_q + YW'(1);
      if (sc_q == YEL)
        yelCntry_d = (yelCntry_q == Y_MAX) ? yelCntry_q : yelCntry_q + YW'(1);
      if (sm_q == RED && sc_q == RED)
        allRed_d = (allRed_q == R_MAX) ? allRed_q : allRed_q + RW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= MONITOR;
    else        state_q <= state_d;
  end

  // FSM next state: any violation traps into FAULT, acknowledge releases it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MONITOR: if (vioCode != 3'd0) state_d = FAULT;
      FAULT:   if (exitFault)       state_d = MONITOR;
      default: state_d = MONITOR;
    endcase
  end

  // FSM outputs: decoded lamps normally, latched code and red flash in FAULT.
  always_comb begin
    mainLamp_d  = lampDecode(sm_q);
    cntryLamp_d = lampDecode(sc_q);
    faultCode_d = 3'd0;
    flash_d     = flash_q;
    flashCnt_d  = flashCnt_q;
    if (state_d == FAULT) begin
      if (state_q == MONITOR) begin
        faultCode_d = vioCode;
        flash_d     = 1'b1;
        flashCnt_d  = '0;
      end else begin
        faultCode_d = faultCode_q;
        if (flashCnt_q == F_LAST) begin
          flash_d    = ~flash_q;
          flashCnt_d = '0;
        end else begin
          flashCnt_d = flashCnt_q + FW'(1);
        end
      end
      mainLamp_d  = {flash_d, 2'b00};
      cntryLamp_d = {flash_d, 2'b00};
    end
  end

  // Sample pipeline, counters and registered outputs.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sm_q        <= RED;
      sc_q        <= RED;
      pm_q        <= RED;
      pc_q        <= RED;
      yelMain_q   <= '0;
      yelCntry_q  <= '0;
      allRed_q    <= R_MAX;
      flash_q     <= 1'b0;
      flashCnt_q  <= '0;
      mainLamp_q  <= 3'b100;
      cntryLamp_q <= 3'b100;
      faultCode_q <= 3'd0;
    end else begin
      sm_q        <= bus.main_sig;
      sc_q        <= bus.cntry_sig;
      pm_q        <= sm_q;
      pc_q        <= sc_q;
      yelMain_q   <= yelMain_d;
      yelCntry_q  <= yelCntry_d;
      allRed_q    <= allRed_d;
      flash_q     <= flash_d;
      flashCnt_q  <= flashCnt_d;
      mainLamp_q  <= mainLamp_d;
      cntryLamp_q <= cntryLamp_d;
      faultCode_q <= faultCode_d;
    end
  end

  assign bus.main_lamp  = mainLamp_q;
  assign bus.cntry_lamp = cntryLamp_q;
  assign bus.fault      = (state_q == FAULT);
  assign bus.fault_code = faultCode_q;

endmodule

// File: tb/tb_traf_sig_monitor.sv
// Testbench for traf_sig_monitor: directed signal sequences with expected
// lamp/fault outputs queued per cycle and compared by a separate monitor.
module tb_traf_sig_monitor;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] Y = 2'd1;
  localparam logic [1:0] G = 2'd2;
  localparam logic [1:0] X = 2'd3;
  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LO = 3'b000;

  typedef struct {
    int         target;
    logic [2:0] ml;
    logic [2:0] cl;
    logic       f;
    logic [2:0] fc;
    string      name;
  } exp_t;

  logic clock = 1'b0;
  logic clear;
  int   cycleCnt = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  traf_sig_monitor_if bus();

  traf_sig_monitor #(
    .MIN_Y_CYC (3),
    .MIN_R_CYC (2),
    .FLASH_HALF(4)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  // Free-running clock and cycle index used to time expectations.
  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input exp_t e);
    checks++;
    if ({bus.main_lamp, bus.cntry_lamp, bus.fault, bus.fault_code} !== {e.ml, e.cl, e.f, e.fc}) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got main=%b cntry=%b fault=%b code=%0d, want main=%b cntry=%b fault=%b code=%0d",
               e.name, cycleCnt, bus.main_lamp, bus.cntry_lamp, bus.fault, bus.fault_code,
               e.ml, e.cl, e.f, e.fc);
    end
  endtask

  function automatic exp_t mkExp(input int tgt, input logic [2:0] ml, input logic [2:0] cl,
                                 input logic f, input logic [2:0] fc, input string nm);
    exp_t e;
    e.target = tgt;
    e.ml     = ml;
    e.cl     = cl;
    e.f      = f;
    e.fc     = fc;
    e.name   = nm;
    return e;
  endfunction

  // Monitor: pop every expectation due this cycle and compare away from the edge.
  always @(negedge clock) begin : monitor
    exp_t e;
    while (sbq.size() > 0 && sbq[0].target <= cycleCnt) begin
      e = sbq.pop_front();
      checkOutput(e);
    end
  end

  // Drive one code pair for n cycles; each drive expects its result two cycles later.
  task automatic applyStimulus(input logic [1:0] m, input logic [1:0] c, input logic ack,
                               input int n, input logic [2:0] eml, input logic [2:0] ecl,
                               input logic ef, input logic [2:0] efc, input string nm);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      bus.main_sig  = m;
      bus.cntry_sig = c;
      bus.fault_ack = ack;
      sbq.push_back(mkExp(cycleCnt + 2, eml, ecl, ef, efc, nm));
    end
  endtask

  // Hold all-red inside the first flash half, then acknowledge. The acknowledge
  // is not pipelined, so the exit shows one cycle earlier than a code change.
  task automatic clearFault(input logic [2:0] code, input string nm);
    applyStimulus(R, R, 1'b0, 2, LR, LR, 1'b1, code, {nm, "Hold"});
    applyStimulus(R, R, 1'b0, 1, LR, LR, 1'b0, 3'd0, {nm, "AckExit"});
    applyStimulus(R, R, 1'b1, 1, LR, LR, 1'b0, 3'd0, {nm, "AckDone"});
    applyStimulus(R, R, 1'b0, 3, LR, LR, 1'b0, 3'd0, {nm, "Settle"});
  endtask

  initial begin
    bus.main_sig  = R;
    bus.cntry_sig = R;
    bus.fault_ack = 1'b0;
    clear = 1'b1;
    #2 clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    sbq.push_back(mkExp(cycleCnt, LR, LR, 1'b0, 3'd0, "resetState"));
    @(posedge clock);
    #1 clear = 1'b1;

    // Legal full cycle: main green/yellow/red, clearance, country green/yellow/red.
    applyStimulus(G, R, 1'b0, 10, LG, LR, 1'b0, 3'd0, "legalMainG");
    applyStimulus(Y, R, 1'b0, 3,  LY, LR, 1'b0, 3'd0, "legalMainY");
    applyStimulus(R, R, 1'b0, 2,  LR, LR, 1'b0, 3'd0, "legalAllRed1");
    applyStimulus(R, G, 1'b0, 10, LR, LG, 1'b0, 3'd0, "legalCntryG");
    applyStimulus(R, Y, 1'b0, 3,  LR, LY, 1'b0, 3'd0, "legalCntryY");
    applyStimulus(R, R, 1'b0, 2,  LR, LR, 1'b0, 3'd0, "legalAllRed2");

    // Conflicting greens and the full flash pattern.
    applyStimulus(G, R, 1'b0, 3, LG, LR, 1'b0, 3'd0, "confPreG");
    applyStimulus(G, G, 1'b0, 1, LR, LR, 1'b1, 3'd2, "confEntry");
    applyStimulus(R, R, 1'b0, 3, LR, LR, 1'b1, 3'd2, "confFlashOn1");
    applyStimulus(R, R, 1'b0, 4, LO, LO, 1'b1, 3'd2, "confFlashOff");
    applyStimulus(R, R, 1'b0, 3, LR, LR, 1'b1, 3'd2, "confFlashOn2");
    applyStimulus(R, R, 1'b0, 1, LR, LR, 1'b0, 3'd0, "confAckExit");
    applyStimulus(R, R, 1'b1, 1, LR, LR, 1'b0, 3'd0, "confAckDone");
    applyStimulus(R, R, 1'b0, 3, LR, LR, 1'b0, 3'd0, "confSettle");

    // Short yellow faults; exactly the minimum yellow does not.
    applyStimulus(G, R, 1'b0, 3, LG, LR, 1'b0, 3'd0, "shortYG");
    applyStimulus(Y, R, 1'b0, 2, LY, LR, 1'b0, 3'd0, "shortYY");
    applyStimulus(R, R, 1'b0, 1, LR, LR, 1'b1, 3'd4, "shortYEntry");
    clearFault(3'd4, "shortY");
    applyStimulus(G, R, 1'b0, 3, LG, LR, 1'b0, 3'd0, "minYG");
    applyStimulus(Y, R, 1'b0, 3, LY, LR, 1'b0, 3'd0, "minYY");
    applyStimulus(R, R, 1'b0, 2, LR, LR, 1'b0, 3'd0, "minYR");

    // Short all-red clearance faults; two all-red cycles do not.
    applyStimulus(G, R, 1'b0, 3, LG, LR, 1'b0, 3'd0, "shortRG");
    applyStimulus(Y, R, 1'b0, 3, LY, LR, 1'b0, 3'd0, "shortRY");
    applyStimulus(R, R, 1'b0, 1, LR, LR, 1'b0, 3'd0, "shortRAllRed");
    applyStimulus(R, G, 1'b0, 1, LR, LR, 1'b1, 3'd5, "shortREntry");
    clearFault(3'd5, "shortR");
    applyStimulus(G, R, 1'b0, 3, LG, LR, 1'b0, 3'd0, "minRG");
    applyStimulus(Y, R, 1'b0, 3, LY, LR, 1'b0, 3'd0, "minRY");
    applyStimulus(R, R, 1'b0, 2, LR, LR, 1'b0, 3'd0, "minRAllRed");
    applyStimulus(R, G, 1'b0, 3, LR, LG, 1'b0, 3'd0, "minRCntryG");
    applyStimulus(R, Y, 1'b0, 3, LR, LY, 1'b0, 3'd0, "minRCntryY");
    applyStimulus(R, R, 1'b0, 2, LR, LR, 1'b0, 3'd0, "minRDone");

    // Priority, latching, and acknowledge ignored while main is green.
    applyStimulus(X, G, 1'b0, 1, LR, LR, 1'b1, 3'd1, "prioEntry");
    applyStimulus(R, G, 1'b0, 1, LR, LR, 1'b1, 3'd1, "prioHoldG");
    applyStimulus(R, R, 1'b0, 1, LR, LR, 1'b1, 3'd1, "prioGtoR");
    applyStimulus(G, R, 1'b0, 1, LR, LR, 1'b1, 3'd1, "prioMainG");
    applyStimulus(G, R, 1'b1, 2, LO, LO, 1'b1, 3'd1, "prioAckGreen");
    applyStimulus(R, R, 1'b0, 2, LO, LO, 1'b1, 3'd1, "prioFlashOff");
    clearFault(3'd1, "prio");

    // Asynchronous reset during the dark flash phase.
    applyStimulus(G, G, 1'b0, 1, LR, LR, 1'b1, 3'd2, "rstEntry");
    applyStimulus(R, R, 1'b0, 3, LR, LR, 1'b1, 3'd2, "rstFlashOn");
    applyStimulus(R, R, 1'b0, 2, LO, LO, 1'b1, 3'd2, "rstFlashOff");
    repeat (3) @(negedge clock);
    #1 clear = 1'b0;
    #1 checkOutput(mkExp(cycleCnt, LR, LR, 1'b0, 3'd0, "asyncReset"));
    sbq.push_back(mkExp(cycleCnt + 1, LR, LR, 1'b0, 3'd0, "resetHeld"));
    @(posedge clock);
    @(negedge clock);
    #1 clear = 1'b1;
    applyStimulus(G, R, 1'b0, 3, LG, LR, 1'b0, 3'd0, "postRstG");
    applyStimulus(Y, R, 1'b0, 3, LY, LR, 1'b0, 3'd0, "postRstY");
    applyStimulus(R, R, 1'b0, 2, LR, LR, 1'b0, 3'd0, "postRstR");

    repeat (4) @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
